load_seq_ctrl: RTL

- Sequences one outstanding data-memory load for the 64-bit core.
- Accepts a load request from the pipeline and issues a doubleword-aligned read with a req/ack handshake to data memory.
- Selects the addressed byte lane and applies ld/lw/lh/lbu extension, then returns the result to writeback through a valid/ready response.
- Sits between the MEM-stage pipeline register and data memory. Detects misalignment and memory timeout.

---
 rtl/core_pkg.sv | 46 ++++
 rtl/load_lane_ext.sv | 33 +++
 rtl/load_seq_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types and helpers for the 64-bit core's load path.
//   XLEN          : architectural register width
//   ld_size_t     : load size/extension encoding as carried by the pipeline
//   ld_err_t      : response error encoding returned to writeback
//   state_t       : load sequencer states
//   is_misaligned : alignment check for a byte offset and load size
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        LD_D  = 2'b00,
        LD_W  = 2'b01,
        LD_H  = 2'b10,
        LD_BU = 2'b11
    } ld_size_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } ld_err_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } state_t;

    // A load is misaligned when its byte offset is not a multiple of its size.
    function automatic logic is_misaligned(input logic [2:0] off, input ld_size_t size);
        logic mis;
        case (size)
            LD_D:    mis = (off != 3'b000);
            LD_W:    mis = (off[1:0] != 2'b00);
            LD_H:    mis = off[0];
            LD_BU:   mis = 1'b0;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_lane_ext.sv
// -----------------------------------------------------------------------------
// load_lane_ext
// Combinational byte-lane select and sign/zero extension of a doubleword read.
// Kept free of any sequencing so the store/AMO path can reuse it.
//   rdata    in  XLEN  doubleword returned by data memory
//   byte_off in  3     byte offset of the access within the doubleword
//   size     in  2     ld / lw / lh / lbu
//   result   out XLEN  lane-shifted, extended load result
// -----------------------------------------------------------------------------
module load_lane_ext
    import core_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      byte_off,
    input  ld_size_t        size,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] lane_s;

    // Shift the addressed byte down to bit 0, then extend according to size.
    always_comb begin
        lane_s = rdata >> {byte_off, 3'b000};
        case (size)
            LD_D:    result = lane_s;
            LD_W:    result = {{32{lane_s[31]}}, lane_s[31:0]};
            LD_H:    result = {{48{lane_s[15]}}, lane_s[15:0]};
            LD_BU:   result = {56'd0, lane_s[7:0]};
            default: result = lane_s;
        endcase
    end

endmodule

// File: rtl/load_seq_ctrl.sv
// -----------------------------------------------------------------------------
// load_seq_ctrl
// Sequences one outstanding data-memory load: accepts a request from the MEM
// stage, issues a doubleword-aligned read with req/ack, extends the addressed
// lane and returns the result (or a misalign/timeout error) to writeback.
//   clk, rst_n                 clock, async active-low reset
//   ld_valid/ld_ready          request handshake; ld_addr/ld_size/ld_tag payload
//   mem_req/mem_addr           aligned read request, held until ack or timeout
//   mem_ack/mem_rdata          read data, sampled only while in REQ
//   rsp_valid/rsp_ready        response handshake; rsp_data/rsp_tag/rsp_err
//   busy                       controller is not idle
// -----------------------------------------------------------------------------
module load_seq_ctrl
    import core_pkg::*;
#(
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [XLEN-1:0]  ld_addr,
    input  logic [1:0]       ld_size,
    input  logic [TAG_W-1:0] ld_tag,
    output logic             mem_req,
    output logic [XLEN-1:0]  mem_addr,
    input  logic             mem_ack,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [1:0]       rsp_err,
    output logic             busy
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t           state_q, state_d;
    logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
    logic [2:0]       off_q, off_d;
    ld_size_t         size_q, size_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [XLEN-1:0]  data_q, data_d;
    ld_err_t          err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_req_q, mem_req_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic [XLEN-1:0]  ext_s;

    load_lane_ext u_lane_ext (
        .rdata    (mem_rdata),
        .byte_off (off_q),
        .size     (size_q),
        .result   (ext_s)
    );

    // Next-state, payload capture and timeout counting.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        off_d      = off_q;
        size_d     = size_q;
        tag_d      = tag_q;
        data_d     = data_q;
        err_d      = err_q;
        cnt_d      = {CNT_W{1'b0}};
        case (state_q)
            IDLE: begin
                if (ld_valid && ld_ready) begin
                    mem_addr_d = {ld_addr[XLEN-1:3], 3'b000};
                    off_d      = ld_addr[2:0];
                    size_d     = ld_size_t'(ld_size);
                    tag_d      = ld_tag;
                    if (is_misaligned(ld_addr[2:0], ld_size_t'(ld_size))) begin
                        // Misaligned loads never touch memory.
                        data_d  = {XLEN{1'b0}};
                        err_d   = ERR_MISALIGN;
                        state_d = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (mem_ack) begin
                    data_d  = ext_s;
                    err_d   = ERR_NONE;
                    state_d = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    data_d  = {XLEN{1'b0}};
                    err_d   = ERR_TIMEOUT;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1'b1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        mem_req_d   = (state_d == REQ);
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers; reset discards any in-flight load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_addr_q  <= {XLEN{1'b0}};
            off_q       <= 3'b000;
            size_q      <= LD_D;
            tag_q       <= {TAG_W{1'b0}};
            data_q      <= {XLEN{1'b0}};
            err_q       <= ERR_NONE;
            cnt_q       <= {CNT_W{1'b0}};
            mem_req_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            off_q       <= off_d;
            size_q      <= size_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign ld_ready  = ~busy_q;
    assign busy      = busy_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = data_q;
    assign rsp_tag   = tag_q;
    assign rsp_err   = err_q;

endmodule
